program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_if.sv | 22 ++
 rtl/program_loader.sv | 118 +++++++++++
 tb/tb_program_loader.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The slave modport is the loader's view; the master modport is the stream source / memory side.
interface program_loader_if #(
    parameter int unsigned ADDR_W = 10
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory
// as 32-bit little-endian words, then releases the processor from halt.
module program_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] base_addr,
    program_loader_if.slave   bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_run,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR} state_t;

    state_t            state, state_nxt;
    logic [7:0]        hdr_lo;
    logic [15:0]       n_words;
    logic [ADDR_W-1:0] base;
    logic [1:0]        byte_idx;
    logic [23:0]       word_acc;
    logic [7:0]        csum;

    logic              active;
    logic              start_ok;
    logic              accept;
    logic [15:0]       n_hdr;
    logic              n_too_big;
    logic              last_byte;
    logic              last_word;

    always_comb begin
        active    = (state == HDR0) || (state == HDR1) || (state == DATA) || (state == CSUM);
        start_ok  = load_start && ((state == IDLE) || (state == DONE) || (state == ERR));
        accept    = active && bus.in_valid;
        n_hdr     = {bus.in_data, hdr_lo};
        n_too_big = 32'(n_hdr) > (32'd1 << ADDR_W);
        last_byte = (byte_idx == 2'd3);
        last_word = (words_loaded + 16'd1) == n_words;
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE, ERR: if (start_ok) state_nxt = HDR0;
            HDR0: if (accept) state_nxt = HDR1;
            HDR1: if (accept) begin
                if (n_hdr == 16'd0)  state_nxt = CSUM;
                else if (n_too_big)  state_nxt = ERR;
                else                 state_nxt = DATA;
            end
            DATA: if (accept && last_byte && last_word) state_nxt = CSUM;
            CSUM: if (accept) state_nxt = (bus.in_data == csum) ? DONE : ERR;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = active;
        busy         = active;
        done         = (state == DONE);
        err          = (state == ERR);
        cpu_run      = (state == DONE);
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            hdr_lo        <= '0;
            n_words       <= '0;
            base          <= '0;
            byte_idx      <= '0;
            word_acc      <= '0;
            csum          <= '0;
            words_loaded  <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            if (start_ok) begin
                base         <= base_addr;
                words_loaded <= '0;
                csum         <= '0;
                byte_idx     <= '0;
            end
            if (accept) begin
                unique case (state)
                    HDR0: hdr_lo  <= bus.in_data;
                    HDR1: n_words <= n_hdr;
                    DATA: begin
                        csum     <= csum ^ bus.in_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (last_byte) begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= base + ADDR_W'(words_loaded);
                            bus.mem_wdata <= {bus.in_data, word_acc};
                            words_loaded  <= words_loaded + 16'd1;
                        end else begin
                            // shift in from the top so byte 0 ends up in [7:0] after three bytes
                            word_acc <= {bus.in_data, word_acc[23:8]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: fixed streams, a vector table and random loads
// compared against a word-list model of the stream format.
module tb_program_loader;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk1 = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          busy, done, err, cpu_run;
    logic [15:0]   words_loaded;

    int checks = 0;
    int errors = 0;
    bit gaps_on = 1'b0;

    logic [AW-1:0] act_addr[$];
    logic [31:0]   act_data[$];
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    logic [31:0]   pay[$];

    program_loader_if #(.ADDR_W(AW)) bus ();

    program_loader #(.ADDR_W(AW)) dut (
        .clk1         (clk1),
        .rst_n        (rst_n),
        .load_start   (load_start),
        .base_addr    (base_addr),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .cpu_run      (cpu_run),
        .words_loaded (words_loaded)
    );

    always #5 clk1 = ~clk1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // write monitor: captures writes, checks strobe width and hold behaviour
    logic          prev_we  = 1'b0;
    logic          prev_rst = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [31:0]   prev_data = '0;
    always @(negedge clk1) begin
        if (bus.mem_we) begin
            act_addr.push_back(bus.mem_addr);
            act_data.push_back(bus.mem_wdata);
            chk("we_while_busy", 32'(busy), 32'd1);
            chk("we_one_cycle", 32'(prev_we), 32'd0);
        end else if (rst_n && prev_rst) begin
            chk("addr_hold", 32'(bus.mem_addr), 32'(prev_addr));
            chk("wdata_hold", bus.mem_wdata, prev_data);
        end
        prev_we   = bus.mem_we;
        prev_rst  = rst_n;
        prev_addr = bus.mem_addr;
        prev_data = bus.mem_wdata;
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset(input bit noisy);
        rst_n = 1'b0;
        if (noisy) begin
            load_start   = 1'b1;
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h5A;
        end
        repeat (2) tick();
        rst_n        = 1'b1;
        load_start   = 1'b0;
        bus.in_valid = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_run", 32'(cpu_run), 32'd0);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_wl", 32'(words_loaded), 32'd0);
    endtask

    task automatic start_load(input logic [AW-1:0] b);
        load_start = 1'b1;
        base_addr  = b;
        tick();
        load_start = 1'b0;
        base_addr  = AW'($urandom);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(bus.in_ready), 32'd1);
        chk("start_done", 32'(done), 32'd0);
        chk("start_err", 32'(err), 32'd0);
        chk("start_wl", 32'(words_loaded), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned gap;
        int unsigned t;
        gap = gaps_on ? $urandom_range(0, 2) : 0;
        repeat (gap) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            tick();
            t++;
        end
        if (!bus.in_ready) begin
            chk("ready_timeout", 32'(bus.in_ready), 32'd1);
        end else begin
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    // reference: word list, expected writes and checksum from the stream rules
    task automatic model_build(input logic [AW-1:0] b, input logic [15:0] n, output logic [7:0] xsum);
        logic [31:0] w;
        pay.delete();
        exp_addr.delete();
        exp_data.delete();
        xsum = 8'h00;
        if (32'(n) <= DEPTH) begin
            for (int unsigned i = 0; i < 32'(n); i++) begin
                w = $urandom;
                pay.push_back(w);
                exp_addr.push_back(AW'((32'(b) + i) % DEPTH));
                exp_data.push_back(w);
                xsum = xsum ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            end
        end
    endtask

    task automatic run_stream(input logic [AW-1:0] b, input logic [15:0] n, input logic [7:0] cs, input bit poke);
        logic [31:0] w;
        act_addr.delete();
        act_data.delete();
        start_load(b);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        if (32'(n) > DEPTH) return;
        for (int i = 0; i < pay.size(); i++) begin
            w = pay[i];
            for (int k = 0; k < 4; k++) begin
                if (poke && i == 0 && k == 0) begin
                    load_start = 1'b1;
                    base_addr  = ~b;
                end
                send_byte(w[8*k +: 8]);
                load_start = 1'b0;
            end
        end
        send_byte(cs);
    endtask

    task automatic check_end(input string nm, input bit ed, input bit ee, input int unsigned ewl);
        int unsigned nw;
        chk({nm, " done"}, 32'(done), 32'(ed));
        chk({nm, " err"}, 32'(err), 32'(ee));
        chk({nm, " cpu_run"}, 32'(cpu_run), 32'(ed));
        chk({nm, " busy"}, 32'(busy), 32'd0);
        chk({nm, " in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({nm, " words_loaded"}, 32'(words_loaded), ewl);
        repeat (3) tick();
        chk({nm, " done_held"}, 32'(done), 32'(ed));
        chk({nm, " err_held"}, 32'(err), 32'(ee));
        chk({nm, " nwrites"}, 32'(act_addr.size()), 32'(exp_addr.size()));
        nw = (act_addr.size() < exp_addr.size()) ? act_addr.size() : exp_addr.size();
        for (int unsigned i = 0; i < nw; i++) begin
            chk({nm, " waddr"}, 32'(act_addr[i]), 32'(exp_addr[i]));
            chk({nm, " wdata"}, act_data[i], exp_data[i]);
        end
    endtask

    task automatic set_fixed();
        pay.delete();
        exp_addr.delete();
        exp_data.delete();
        pay.push_back(32'h280A00C8);
        pay.push_back(32'h28020001);
        exp_addr.push_back(AW'(0));
        exp_addr.push_back(AW'(1));
        exp_data.push_back(32'h280A00C8);
        exp_data.push_back(32'h28020001);
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [15:0]   n;
        bit            good_csum;
        bit            poke;
        bit            gaps;
        bit            exp_done;
        bit            exp_err;
        int unsigned   exp_wl;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [7:0] xs;
        logic [7:0] cs;
        logic [AW-1:0] rb;
        logic [15:0]   rn;
        bit good;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        do_reset(1'b0);

        set_fixed();
        run_stream(AW'(0), 16'd2, 8'hC1, 1'b0);
        check_end("good_load", 1'b1, 1'b0, 2);

        gaps_on = 1'b1;
        set_fixed();
        run_stream(AW'(0), 16'd2, 8'hC1, 1'b0);
        check_end("good_load_gaps", 1'b1, 1'b0, 2);
        gaps_on = 1'b0;

        set_fixed();
        run_stream(AW'(0), 16'd2, 8'h00, 1'b0);
        check_end("bad_csum", 1'b0, 1'b1, 2);

        model_build(AW'(0), 16'd0, xs);
        run_stream(AW'(0), 16'd0, 8'h00, 1'b0);
        check_end("empty_load", 1'b1, 1'b0, 0);

        model_build(AW'(0), 16'h0401, xs);
        run_stream(AW'(0), 16'h0401, 8'h00, 1'b0);
        check_end("too_long", 1'b0, 1'b1, 0);

        // abort mid-word, then a fresh load must write only its own words
        start_load(AW'(10'h055));
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i));
        act_addr.delete();
        act_data.delete();
        do_reset(1'b1);
        repeat (4) tick();
        chk("abort_no_write", 32'(act_addr.size()), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);
        gaps_on = 1'b1;
        set_fixed();
        run_stream(AW'(0), 16'd2, 8'hC1, 1'b0);
        check_end("after_abort", 1'b1, 1'b0, 2);
        gaps_on = 1'b0;

        tbl[0] = '{10'h3FF, 16'd2,     1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        tbl[1] = '{10'h005, 16'd0,     1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[2] = '{10'h005, 16'd0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[3] = '{10'h100, 16'd3,     1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3};
        tbl[4] = '{10'h3FE, 16'd5,     1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5};
        tbl[5] = '{10'h000, 16'd1025,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[6] = '{10'h007, 16'd1024,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1024};
        tbl[7] = '{10'h001, 16'hFFFF,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0};
        tbl[8] = '{10'h2AA, 16'd1,     1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1};

        for (int v = 0; v < 9; v++) begin
            gaps_on = tbl[v].gaps;
            model_build(tbl[v].base, tbl[v].n, xs);
            cs = tbl[v].good_csum ? xs : (xs ^ 8'h5A);
            run_stream(tbl[v].base, tbl[v].n, cs, tbl[v].poke);
            check_end($sformatf("vec%0d", v), tbl[v].exp_done, tbl[v].exp_err, tbl[v].exp_wl);
        end

        for (int r = 0; r < 30; r++) begin
            gaps_on = 1'($urandom);
            rb      = AW'($urandom);
            rn      = 16'($urandom_range(0, 6));
            good    = 1'($urandom);
            model_build(rb, rn, xs);
            cs = good ? xs : 8'($urandom);
            run_stream(rb, rn, cs, 1'($urandom));
            check_end($sformatf("rand%0d", r), cs == xs, cs != xs, 32'(rn));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
